// File: rtl/cfi_log_queue.sv
// rtl/cfi_log_queue.sv - in-order circular queue serialising CFI log records to one checker
package cfi_log_pkg;
    typedef struct packed {
        logic [3:0]  flags;
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] target;
    } cfi_log_t;
endpackage

module cfi_log_queue
    import cfi_log_pkg::*;
#(
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned DEPTH           = 8,
    parameter int unsigned CNT_W           = 32
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             en_i,
    input  logic                             flush_i,
    input  cfi_log_t [NR_COMMIT_PORTS-1:0]   log_i,
    input  logic [NR_COMMIT_PORTS-1:0]       cfi_i,
    output cfi_log_t                         log_o,
    output logic                             valid_o,
    input  logic                             ready_i,
    output logic                             stall_o,
    output logic [$clog2(DEPTH):0]           usage_o,
    output logic [CNT_W-1:0]                 drop_cnt_o,
    output logic                             overflow_o
);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_QW = PTR_W + 1;

    cfi_log_t                    mem [DEPTH];
    logic [PTR_W-1:0]            wr_ptr;
    logic [PTR_W-1:0]            rd_ptr;
    logic [CNT_QW-1:0]           count;
    logic [CNT_QW-1:0]           free;
    logic [CNT_QW-1:0]           n_req;
    logic [CNT_QW-1:0]           n_acc;
    logic [CNT_QW-1:0]           n_drop;
    logic [NR_COMMIT_PORTS-1:0]  accept;
    logic [PTR_W-1:0]            waddr [NR_COMMIT_PORTS];
    logic                        deq;
    logic [CNT_W-1:0]            drop_cnt;
    logic [CNT_W:0]              drop_sum;
    logic                        overflow;

    // Space comes only from registered occupancy; a same-cycle pop never frees a slot.
    assign free = CNT_QW'(DEPTH) - count;

    // Requesters take consecutive slots in port order; the ones past the free space drop.
    always_comb begin
        n_req  = '0;
        n_acc  = '0;
        accept = '0;
        for (int p = 0; p < int'(NR_COMMIT_PORTS); p++) begin
            waddr[p] = wr_ptr + n_req[PTR_W-1:0];
            if (en_i && cfi_i[p]) begin
                if (n_req < free) begin
                    accept[p] = 1'b1;
                    n_acc     = n_acc + CNT_QW'(1);
                end
                n_req = n_req + CNT_QW'(1);
            end
        end
        n_drop = n_req - n_acc;
    end

    assign valid_o    = (count != '0);
    assign deq        = valid_o && ready_i;
    assign log_o      = mem[rd_ptr];
    assign usage_o    = count;
    assign stall_o    = (free < CNT_QW'(NR_COMMIT_PORTS));
    assign drop_cnt_o = drop_cnt;
    assign overflow_o = overflow;
    assign drop_sum   = {1'b0, drop_cnt} + (CNT_W+1)'(n_drop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + n_acc[PTR_W-1:0];
            if (deq) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + n_acc - CNT_QW'(deq);
            if (n_drop != '0) begin
                drop_cnt <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
                overflow <= 1'b1;
            end
        end
    end

    // Storage carries no reset; stale contents are masked by valid_o.
    always_ff @(posedge clk_i) begin
        if (!rst_i && !flush_i) begin
            for (int p = 0; p < int'(NR_COMMIT_PORTS); p++) begin
                if (accept[p]) begin
                    mem[waddr[p]] <= log_i[p];
                end
            end
        end
    end
endmodule

// File: tb/tb_cfi_log_queue.sv
// tb/tb_cfi_log_queue.sv - randomized bench for cfi_log_queue against a queue-based model
module tb_cfi_log_queue;
    import cfi_log_pkg::*;

    localparam int NP    = 2;
    localparam int DEPTH = 8;
    localparam int CNT_W = 32;

    logic                 clk = 1'b0;
    logic                 rst_i, en_i, flush_i, ready_i;
    cfi_log_t [NP-1:0]    log_i;
    logic [NP-1:0]        cfi_i;
    cfi_log_t             log_o;
    logic                 valid_o, stall_o, overflow_o;
    logic [$clog2(DEPTH):0] usage_o;
    logic [CNT_W-1:0]     drop_cnt_o;

    cfi_log_queue #(.NR_COMMIT_PORTS(NP), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .flush_i(flush_i),
        .log_i(log_i), .cfi_i(cfi_i), .log_o(log_o), .valid_o(valid_o),
        .ready_i(ready_i), .stall_o(stall_o), .usage_o(usage_o),
        .drop_cnt_o(drop_cnt_o), .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    cfi_log_t    mq[$];
    longint      m_drop;
    bit          m_ovf;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic cfi_log_t rand_log();
        cfi_log_t r;
        r.flags  = 4'($urandom);
        r.pc     = $urandom;
        r.npc    = $urandom;
        r.target = $urandom;
        return r;
    endfunction

    task automatic check_outputs();
        check("valid", 128'(valid_o), 128'(mq.size() != 0));
        check("usage", 128'(usage_o), 128'(mq.size()));
        check("stall", 128'(stall_o), 128'((DEPTH - mq.size()) < NP));
        check("drop_cnt", 128'(drop_cnt_o), 128'(m_drop));
        check("overflow", 128'(overflow_o), 128'(m_ovf));
        if (mq.size() != 0) check("log_head", 128'(log_o), 128'(mq[0]));
    endtask

    // Drive one cycle of inputs, advance the model by the same rules, then compare.
    task automatic step(input bit r, input bit e, input bit f, input bit rdy, input logic [NP-1:0] c);
        int free, nreq, nacc;
        bit deq;
        cfi_log_t newq[$];
        rst_i = r; en_i = e; flush_i = f; ready_i = rdy; cfi_i = c;
        for (int p = 0; p < NP; p++) log_i[p] = rand_log();
        if (r) begin
            mq.delete(); m_drop = 0; m_ovf = 0;
        end else if (f) begin
            mq.delete();
        end else begin
            free = DEPTH - mq.size();
            deq  = (mq.size() != 0) && rdy;
            nreq = 0; nacc = 0;
            for (int p = 0; p < NP; p++) begin
                if (e && c[p]) begin
                    if (nreq < free) begin
                        newq.push_back(log_i[p]);
                        nacc++;
                    end
                    nreq++;
                end
            end
            if (nreq > nacc) begin
                m_drop = m_drop + (nreq - nacc);
                if (m_drop > 64'hFFFF_FFFF) m_drop = 64'hFFFF_FFFF;
                m_ovf = 1'b1;
            end
            if (deq) void'(mq.pop_front());
            foreach (newq[i]) mq.push_back(newq[i]);
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        rst_i = 1'b1; en_i = 1'b1; flush_i = 1'b0; ready_i = 1'b0; cfi_i = '0; log_i = '0;
        m_drop = 0; m_ovf = 0;

        // Reset with requests present
        step(1, 1, 0, 0, 2'b11);
        step(1, 1, 0, 0, 2'b11);
        check("rst_usage", 128'(usage_o), 128'(0));
        check("rst_valid", 128'(valid_o), 128'(0));

        // Ordering and packing
        step(0, 1, 0, 0, 2'b10);
        step(0, 1, 0, 0, 2'b11);
        check("order_usage3", 128'(usage_o), 128'(3));
        for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 2'b00);
        check("order_empty", 128'(valid_o), 128'(0));

        // Overflow: five double requests into an 8-deep queue
        step(1, 1, 0, 0, 2'b00);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 2'b11);
        check("ovf_drop2", 128'(drop_cnt_o), 128'(2));
        check("ovf_sticky", 128'(overflow_o), 128'(1));
        check("ovf_usage8", 128'(usage_o), 128'(8));
        check("ovf_stall", 128'(stall_o), 128'(1));

        // Full with simultaneous dequeue
        step(0, 1, 0, 1, 2'b01);
        check("full_deq_drop", 128'(drop_cnt_o), 128'(3));
        check("full_deq_usage", 128'(usage_o), 128'(7));

        // Flush mid-stream
        step(1, 1, 0, 0, 2'b00);
        step(0, 1, 0, 0, 2'b11);
        step(0, 1, 0, 0, 2'b11);
        step(0, 1, 0, 0, 2'b01);
        step(0, 1, 1, 1, 2'b11);
        check("flush_usage", 128'(usage_o), 128'(0));
        check("flush_drop", 128'(drop_cnt_o), 128'(0));

        // Wrap-around: park pointers at 7, then straddle the end
        step(0, 1, 0, 0, 2'b11);
        step(0, 1, 0, 0, 2'b11);
        step(0, 1, 0, 0, 2'b11);
        step(0, 1, 0, 0, 2'b01);
        for (int i = 0; i < 7; i++) step(0, 1, 0, 1, 2'b00);
        step(0, 1, 0, 0, 2'b11);
        step(0, 1, 0, 1, 2'b00);
        step(0, 1, 0, 1, 2'b00);

        // Enable low ignores requests
        step(0, 0, 0, 0, 2'b11);
        check("en_low_usage", 128'(usage_o), 128'(0));

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 9) != 0,
                 $urandom_range(0, 29) == 0,
                 1'($urandom),
                 NP'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
